video_out_stage: RTL and testbench
==================================

VIDEO_OUT_STAGE -- requirements
Module: video_out_stage

Interface
REQ-001 SHALL have parameter IN_BITS, default 3, per-channel input colour width (1..8).
REQ-002 SHALL have parameter HS_POL, default 0, output hsync active level (0 = active-low).
REQ-003 SHALL have parameter VS_POL, default 0, output vsync active level (0 = active-low).
REQ-004 SHALL have port clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ce_pix  in  1  pixel clock enable.
REQ-007 SHALL have port rgb_i  in  3*IN_BITS  packed colour: blue in the high third, green in the middle third, red in the low third.
REQ-008 SHALL have ports hsync_i, vsync_i, hblank_i, vblank_i  in  1 each  active-high core timing.
REQ-009 SHALL have port blank_en  in  1  force black while blanking.
REQ-010 SHALL have port scanline_i  in  2  odd-line dim: 0 none, 1 25%, 2 50%, 3 75%.
REQ-011 SHALL have ports VGA_R, VGA_G, VGA_B  out  8 each  expanded colour.
REQ-012 SHALL have ports VGA_HS, VGA_VS, VGA_DE  out  1 each  polarity-adjusted syncs; DE = not hblank and not vblank.
REQ-013 SHALL have port frame_done  out  1  one-clk_sys pulse on each vblank_i rising edge.
REQ-014 SHALL have ports line_pixels, frame_lines  out  12 each, and stats_valid  out  1  timing measurement.

Function
REQ-015 SHALL expand each channel to 8 bits by MSB-first bit replication truncated to 8 (IN_BITS=3: {v,v,v[2:1]}; IN_BITS=8: unchanged).
REQ-016 SHALL register all video outputs, updating only on ce_pix, with latency exactly one ce_pix-qualified cycle from inputs.
REQ-017 SHALL drive VGA_HS = hsync_i XNOR HS_POL and VGA_VS = vsync_i XNOR VS_POL, aligned with colour.
REQ-018 SHALL output 0 on all three channels when blank_en=1 and (hblank_i or vblank_i).
REQ-019 SHALL track line parity: toggle on each ce_pix-sampled hblank_i rising edge; clear to even on vblank_i rising edge.
REQ-020 SHALL, on odd lines, dim each expanded 8-bit value x to x - (x>>2), x>>1, or x>>2 for scanline_i 1, 2, 3; no underflow possible.
REQ-021 SHALL detect edges of hblank_i/vblank_i on ce_pix cycles only; frame_done pulses the clk_sys cycle after detection.
REQ-022 SHALL count ce_pix cycles with hblank_i low; on hblank_i rising edge latch into line_pixels and clear the counter.
REQ-023 SHALL count hblank_i falling edges while vblank_i low; on vblank_i rising edge latch into frame_lines and clear.
REQ-024 SHALL saturate both counters at 4095.
REQ-025 SHALL set stats_valid at the second vblank_i rising edge after reset (first frame partial), holding it until reset.
REQ-026 SHALL apply blanking (REQ-018) before dimming; a simultaneous hblank rising edge and dim applies the pre-toggle parity.

Reset
REQ-027 SHALL on reset drive VGA_R/G/B=0, VGA_DE=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, frame_done=0.
REQ-028 SHALL on reset clear parity, counters, line_pixels, frame_lines, stats_valid; reset mid-frame discards the partial measurement.

Configuration
REQ-029 SHALL compile measurement logic (REQ-022..025) only when VIDEO_STATS_EN is defined; otherwise line_pixels, frame_lines and stats_valid are tied 0, and frame_done and scanline behaviour are unchanged.

Structure
REQ-030 SHALL place the expansion function, the dim-mode constants, and STAT_W=12 in shared package video_pkg.
REQ-031 SHALL implement per-channel expand+dim in sub-module video_expand, instantiated three times.

Verification
REQ-032 IN_BITS=3, rgb_i=9'b101_011_110 (B=5,G=3,R=6), ce_pix every cycle -> one ce_pix later R=8'hDB, G=8'h6D, B=8'hB6.
REQ-033 HS_POL=0, hsync_i=1 -> VGA_HS=0 one ce_pix later; during reset -> VGA_HS=1, VGA_VS=1, colours 0.
REQ-034 Odd line, scanline_i=2, R expands to 8'hFF -> VGA_R=8'h7F; scanline_i=3 -> 8'h3F; even line -> 8'hFF.
REQ-035 blank_en=1, hblank_i=1, rgb_i all-ones -> colours 0, VGA_DE=0; blank_en=0 -> colours 8'hFF, VGA_DE=0.
REQ-036 VIDEO_STATS_EN, 256 active pixels x 224 active lines, ce_pix every 2nd clock -> after second vblank rise line_pixels=256, frame_lines=224, stats_valid=1; frame_done one clk wide per frame.
REQ-037 Reset asserted mid-frame then released -> stats_valid stays 0 through the first vblank rise, is 1 after the second; without VIDEO_STATS_EN stats outputs stay 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video output stage: channel bit-replication
// expansion, scanline dim modes and the timing-statistics width.
package video_pkg;

  localparam int unsigned STAT_W = 12;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  typedef enum logic [1:0] {
    DIM_NONE = 2'd0,
    DIM_25   = 2'd1,
    DIM_50   = 2'd2,
    DIM_75   = 2'd3
  } dim_mode_t;

  // v holds the channel right-aligned in its low 'bits' bits; result repeats
  // it MSB-first until all 8 output bits are filled.
  function automatic logic [7:0] expand_chan(input logic [7:0] v, input int unsigned bits);
    logic [7:0] r;
    logic [2:0] src;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      src = 3'(bits - 1 - (i % bits));
      r[3'(7 - i)] = v[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/video_expand.sv
// One colour channel: expand to 8 bits, then force black or apply odd-line dim.
module video_expand import video_pkg::*; #(
  parameter int unsigned IN_BITS = 3
) (
  input  logic [IN_BITS-1:0] i_val,
  input  logic               i_black,
  input  logic               i_odd,
  input  logic [1:0]         i_mode,
  output logic [7:0]         o_val
);

  logic [7:0] w_exp;

  // Blanking wins over dimming; dimmed values never underflow.
  always_comb begin
    w_exp = expand_chan(8'(i_val), IN_BITS);
    o_val = w_exp;
    if (i_black) begin
      o_val = '0;
    end else if (i_odd) begin
      case (dim_mode_t'(i_mode))
        DIM_25:  o_val = w_exp - (w_exp >> 2);
        DIM_50:  o_val = w_exp >> 1;
        DIM_75:  o_val = w_exp >> 2;
        default: o_val = w_exp;
      endcase
    end
  end

endmodule

// File: rtl/video_out_stage.sv
// Registered video output stage: colour expansion, blanking, scanline dim,
// sync polarity. Timing measurement is built only with VIDEO_STATS_EN defined.
module video_out_stage import video_pkg::*; #(
  parameter int unsigned IN_BITS = 3,
  parameter logic        HS_POL  = 1'b0,
  parameter logic        VS_POL  = 1'b0
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce_pix,
  input  logic [3*IN_BITS-1:0] rgb_i,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  input  logic                 hblank_i,
  input  logic                 vblank_i,
  input  logic                 blank_en,
  input  logic [1:0]           scanline_i,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_DE,
  output logic                 frame_done,
  output logic [STAT_W-1:0]    line_pixels,
  output logic [STAT_W-1:0]    frame_lines,
  output logic                 stats_valid
);

  logic       r_hb_d;
  logic       r_vb_d;
  logic       r_odd;
  logic       w_hb_rise;
  logic       w_vb_rise;
  logic       w_black;
  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;

  assign w_hb_rise = ce_pix & hblank_i & ~r_hb_d;
  assign w_vb_rise = ce_pix & vblank_i & ~r_vb_d;
  assign w_black   = blank_en & (hblank_i | vblank_i);

  video_expand #(.IN_BITS(IN_BITS)) u_exp_r (
    .i_val(rgb_i[IN_BITS-1:0]), .i_black(w_black), .i_odd(r_odd),
    .i_mode(scanline_i), .o_val(w_r)
  );
  video_expand #(.IN_BITS(IN_BITS)) u_exp_g (
    .i_val(rgb_i[2*IN_BITS-1:IN_BITS]), .i_black(w_black), .i_odd(r_odd),
    .i_mode(scanline_i), .o_val(w_g)
  );
  video_expand #(.IN_BITS(IN_BITS)) u_exp_b (
    .i_val(rgb_i[3*IN_BITS-1:2*IN_BITS]), .i_black(w_black), .i_odd(r_odd),
    .i_mode(scanline_i), .o_val(w_b)
  );

  // Colour is captured with the parity held before this cycle's toggle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hb_d     <= 1'b0;
      r_vb_d     <= 1'b0;
      r_odd      <= 1'b0;
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
      VGA_HS     <= ~HS_POL;
      VGA_VS     <= ~VS_POL;
      VGA_DE     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_vb_rise;
      if (ce_pix) begin
        r_hb_d <= hblank_i;
        r_vb_d <= vblank_i;
        if (w_vb_rise)
          r_odd <= 1'b0;
        else if (w_hb_rise)
          r_odd <= ~r_odd;
        VGA_R  <= w_r;
        VGA_G  <= w_g;
        VGA_B  <= w_b;
        VGA_HS <= ~(hsync_i ^ HS_POL);
        VGA_VS <= ~(vsync_i ^ VS_POL);
        VGA_DE <= ~(hblank_i | vblank_i);
      end
    end
  end

`ifdef VIDEO_STATS_EN
  logic [STAT_W-1:0] r_pix_cnt;
  logic [STAT_W-1:0] r_line_cnt;
  logic [STAT_W-1:0] r_line_pixels;
  logic [STAT_W-1:0] r_frame_lines;
  logic              r_seen_vb;
  logic              r_stats_valid;
  logic              w_hb_fall;

  assign w_hb_fall = ce_pix & ~hblank_i & r_hb_d;

  // The first vblank after reset closes a partial frame, so valid waits for the second.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_line_pixels <= '0;
      r_frame_lines <= '0;
      r_seen_vb     <= 1'b0;
      r_stats_valid <= 1'b0;
    end else if (ce_pix) begin
      if (w_hb_rise) begin
        r_line_pixels <= r_pix_cnt;
        r_pix_cnt     <= '0;
      end else if (!hblank_i && r_pix_cnt != STAT_MAX) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
      if (w_vb_rise) begin
        r_frame_lines <= r_line_cnt;
        r_line_cnt    <= '0;
        r_seen_vb     <= 1'b1;
        if (r_seen_vb)
          r_stats_valid <= 1'b1;
      end else if (w_hb_fall && !vblank_i && r_line_cnt != STAT_MAX) begin
        r_line_cnt <= r_line_cnt + 1'b1;
      end
    end
  end

  assign line_pixels = r_line_pixels;
  assign frame_lines = r_frame_lines;
  assign stats_valid = r_stats_valid;
`else
  assign line_pixels = '0;
  assign frame_lines = '0;
  assign stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_out_stage.sv
// Self-checking bench for video_out_stage: arithmetic reference model checked
// every cycle, plus directed literal checks. Stats checks follow VIDEO_STATS_EN.
module tb_video_out_stage;

  localparam int unsigned IN_BITS = 3;
  localparam logic        HS_POL  = 1'b0;
  localparam logic        VS_POL  = 1'b0;
  localparam int          RGB_W   = 3 * IN_BITS;
  localparam int          FW = 32, FHB = 8, FH = 12, FVB = 3, FTOT = FH + FVB;

  logic             clk_sys = 1'b0;
  logic             reset = 1'b1;
  logic             ce_pix = 1'b0;
  logic [RGB_W-1:0] rgb_i = '0;
  logic             hsync_i = 1'b0, vsync_i = 1'b0, hblank_i = 1'b0, vblank_i = 1'b0;
  logic             blank_en = 1'b0;
  logic [1:0]       scanline_i = 2'd0;
  logic [7:0]       VGA_R, VGA_G, VGA_B;
  logic             VGA_HS, VGA_VS, VGA_DE, frame_done, stats_valid;
  logic [11:0]      line_pixels, frame_lines;

  int vectors = 0;
  int miscompares = 0;
  int fd_count = 0;
  bit chk_en = 1'b0;

  video_out_stage #(.IN_BITS(IN_BITS), .HS_POL(HS_POL), .VS_POL(VS_POL)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .rgb_i(rgb_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
    .blank_en(blank_en), .scanline_i(scanline_i),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE), .frame_done(frame_done),
    .line_pixels(line_pixels), .frame_lines(frame_lines), .stats_valid(stats_valid)
  );

  always #5 clk_sys = ~clk_sys;

  // Expansion as the top 8 bits of the channel value repeated end to end.
  function automatic int exp_model(input int v);
    longint unsigned rep;
    rep = 0;
    for (int k = 0; k < 8; k++) rep = (rep << IN_BITS) | longint'(v);
    return int'(rep >> (8 * IN_BITS - 8));
  endfunction

  function automatic int dim_model(input int e, input int mode);
    case (mode)
      1:       return e - e / 4;
      2:       return e / 2;
      3:       return e / 4;
      default: return e;
    endcase
  endfunction

  function automatic int chan(input logic [RGB_W-1:0] rgb, input int idx);
    return int'((rgb >> (idx * IN_BITS)) & RGB_W'((1 << IN_BITS) - 1));
  endfunction

  // Reference model state
  int   e_r, e_g, e_b;
  bit   e_hs, e_vs, e_de, e_fd;
  bit   m_odd, m_hb, m_vb;
  int   m_pix, m_lines, m_lp, m_fl, m_vrises;

  always @(posedge clk_sys) begin
    bit hb_r, hb_f, vb_r, blk;
    int mode;
    if (reset) begin
      e_r = 0; e_g = 0; e_b = 0;
      e_hs = !HS_POL; e_vs = !VS_POL; e_de = 0; e_fd = 0;
      m_odd = 0; m_hb = 0; m_vb = 0;
      m_pix = 0; m_lines = 0; m_lp = 0; m_fl = 0; m_vrises = 0;
    end else begin
      hb_r = ce_pix && hblank_i && !m_hb;
      hb_f = ce_pix && !hblank_i && m_hb;
      vb_r = ce_pix && vblank_i && !m_vb;
      e_fd = vb_r;
      if (ce_pix) begin
        blk  = blank_en && (hblank_i || vblank_i);
        mode = m_odd ? int'(scanline_i) : 0;
        e_r  = blk ? 0 : dim_model(exp_model(chan(rgb_i, 0)), mode);
        e_g  = blk ? 0 : dim_model(exp_model(chan(rgb_i, 1)), mode);
        e_b  = blk ? 0 : dim_model(exp_model(chan(rgb_i, 2)), mode);
        e_hs = (hsync_i == HS_POL);
        e_vs = (vsync_i == VS_POL);
        e_de = !(hblank_i || vblank_i);
        if (!hblank_i) m_pix++;
        if (hb_r) begin m_lp = m_pix; m_pix = 0; end
        if (hb_f && !vblank_i) m_lines++;
        if (vb_r) begin m_fl = m_lines; m_lines = 0; m_vrises++; end
        if (vb_r) m_odd = 0;
        else if (hb_r) m_odd = !m_odd;
        m_hb = hblank_i;
        m_vb = vblank_i;
      end
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk_sys) begin
    int x_lp, x_fl;
    bit x_sv;
    if (chk_en) begin
`ifdef VIDEO_STATS_EN
      x_lp = (m_lp > 4095) ? 4095 : m_lp;
      x_fl = (m_fl > 4095) ? 4095 : m_fl;
      x_sv = (m_vrises >= 2);
`else
      x_lp = 0; x_fl = 0; x_sv = 0;
`endif
      if (frame_done === 1'b1) fd_count++;
      vectors++;
      if (VGA_R !== 8'(e_r) || VGA_G !== 8'(e_g) || VGA_B !== 8'(e_b) ||
          VGA_HS !== e_hs || VGA_VS !== e_vs || VGA_DE !== e_de || frame_done !== e_fd ||
          line_pixels !== 12'(x_lp) || frame_lines !== 12'(x_fl) || stats_valid !== x_sv) begin
        miscompares++;
        $display("FAIL outputs t=%0t act/exp R=%h/%h G=%h/%h B=%h/%h HS=%b/%b VS=%b/%b DE=%b/%b FD=%b/%b LP=%0d/%0d FL=%0d/%0d SV=%b/%b",
                 $time, VGA_R, 8'(e_r), VGA_G, 8'(e_g), VGA_B, 8'(e_b), VGA_HS, e_hs, VGA_VS, e_vs,
                 VGA_DE, e_de, frame_done, e_fd, line_pixels, x_lp, frame_lines, x_fl, stats_valid, x_sv);
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; ce_pix = 1'b0;
    hblank_i = 1'b0; vblank_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  function automatic bit is_vb_line(input int l);
    return (l % FTOT) >= FH;
  endfunction

  // Frame timing with ce_pix every second clock; vblank changes mid-hblank.
  task automatic run_lines(input int l0, input int n);
    int t;
    for (int l = l0; l < l0 + n; l++) begin
      for (int x = 0; x < FW + FHB; x++) begin
        hblank_i   = (x >= FW);
        vblank_i   = (x < FW + 2) ? is_vb_line(l) : is_vb_line(l + 1);
        hsync_i    = (x >= FW + 1) && (x < FW + 5);
        vsync_i    = ((l % FTOT) == FH + 1);
        t          = l * 37 + x * 11;
        rgb_i      = t[RGB_W-1:0];
        scanline_i = l[1:0];
        blank_en   = l[1];
        ce_pix = 1'b1; tick();
        ce_pix = 1'b0; tick();
      end
    end
  endtask

  task automatic chk_stats(input string tag, input int lp, input int fl, input int sv);
`ifdef VIDEO_STATS_EN
    chk({tag, "_line_pixels"}, int'(line_pixels), lp);
    chk({tag, "_frame_lines"}, int'(frame_lines), fl);
    chk({tag, "_stats_valid"}, int'(stats_valid), sv);
`else
    chk({tag, "_line_pixels"}, int'(line_pixels), 0);
    chk({tag, "_frame_lines"}, int'(frame_lines), 0);
    chk({tag, "_stats_valid"}, int'(stats_valid), 0);
`endif
  endtask

  initial begin
    // Reset behaviour: inactive syncs, black, no DE, even with hsync_i high.
    hsync_i = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_HS", int'(VGA_HS), 1);
    chk("rst_VS", int'(VGA_VS), 1);
    chk("rst_R", int'(VGA_R), 0);
    chk("rst_DE", int'(VGA_DE), 0);
    chk("rst_FD", int'(frame_done), 0);
    reset = 1'b0;

    // Expansion and one-cycle latency.
    rgb_i = 9'b101_011_110; hsync_i = 1'b1; ce_pix = 1'b1; tick();
    chk("model_R", e_r, 8'hDB);
    chk("model_G", e_g, 8'h6D);
    chk("model_B", e_b, 8'hB6);
    chk("exp_R", int'(VGA_R), 8'hDB);
    chk("exp_G", int'(VGA_G), 8'h6D);
    chk("exp_B", int'(VGA_B), 8'hB6);
    chk("hs_active", int'(VGA_HS), 0);
    chk("de_active", int'(VGA_DE), 1);

    ce_pix = 1'b0; rgb_i = '1; hsync_i = 1'b0; tick();
    chk("hold_R", int'(VGA_R), 8'hDB);
    ce_pix = 1'b1; tick();
    chk("white_R", int'(VGA_R), 8'hFF);
    chk("hs_idle", int'(VGA_HS), 1);

    // Scanline dimming; hblank rise uses pre-toggle parity.
    hblank_i = 1'b1; scanline_i = 2'd2; tick();
    chk("even_rise_R", int'(VGA_R), 8'hFF);
    hblank_i = 1'b0; tick();
    chk("odd50_R", int'(VGA_R), 8'h7F);
    chk("odd50_G", int'(VGA_G), 8'h7F);
    scanline_i = 2'd3; tick();
    chk("odd75_R", int'(VGA_R), 8'h3F);
    scanline_i = 2'd1; tick();
    chk("odd25_R", int'(VGA_R), 8'hC0);
    scanline_i = 2'd2; hblank_i = 1'b1; tick();
    chk("odd_rise_R", int'(VGA_R), 8'h7F);

    // Blanking.
    blank_en = 1'b1; tick();
    chk("blank_R", int'(VGA_R), 0);
    chk("blank_B", int'(VGA_B), 0);
    chk("blank_DE", int'(VGA_DE), 0);
    blank_en = 1'b0; tick();
    chk("noblank_G", int'(VGA_G), 8'hFF);
    chk("noblank_DE", int'(VGA_DE), 0);
    hblank_i = 1'b0; tick();
    chk("even_R", int'(VGA_R), 8'hFF);

    // frame_done is a single clk_sys pulse after the vblank rise.
    vblank_i = 1'b1; tick();
    chk("fd_pulse", int'(frame_done), 1);
    ce_pix = 1'b0; tick();
    chk("fd_clear", int'(frame_done), 0);
    vblank_i = 1'b0;

    // Frames with ce_pix every second clock.
    do_reset(3);
    fd_count = 0;
    run_lines(0, FTOT);
    chk_stats("frame1", FW, FH - 1, 0);
    run_lines(FTOT, FTOT);
    chk_stats("frame2", FW, FH, 1);
    chk("fd_count2", fd_count, 2);

    // Reset mid-frame: the partial frame after release does not validate stats.
    run_lines(2 * FTOT, 6);
    do_reset(4);
    chk_stats("midrst", 0, 0, 0);
    run_lines(2 * FTOT + 6, FTOT - 6);
    chk_stats("partial", FW, 5, 0);
    run_lines(3 * FTOT, FTOT);
    chk_stats("full", FW, FH, 1);
    chk("fd_count4", fd_count, 4);

    // Pixel counter saturation on an over-long line.
    do_reset(2);
    blank_en = 1'b0; hblank_i = 1'b0; vblank_i = 1'b0; ce_pix = 1'b1;
    for (int i = 0; i < 4100; i++) tick();
    hblank_i = 1'b1; tick();
    tick();
    ce_pix = 1'b0; tick();
    chk_stats("sat", 4095, 0, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
